// File: rtl/uart_cmd_parser.sv
// Line-oriented register console: pops RX bytes, runs W<aa><dd> / R<aa> commands, replies via TX.
// Optional UART_CMD_ECHO_EN echoes stored chars and prefixes each reply with CRLF.
module uart_cmd_parser #(
  parameter int unsigned MAX_LINE            = 8,
  parameter int unsigned LINE_TIMEOUT_CYCLES = 27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data_out,
  output logic       rx_fifo_read_en,
  input  logic       uart_tx_fifo_ready,
  output logic       start_uart_tx,
  output logic [7:0] uart_tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       cmd_busy
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
`ifdef UART_CMD_ECHO_EN
  localparam logic [2:0] S_ECHO  = 3'd5;
  localparam int unsigned Pre    = 2;
`else
  localparam int unsigned Pre    = 0;
`endif

  // Only the first five chars can form a valid command; longer lines are counted, not stored.
  localparam int unsigned BufBytes = 5;
  localparam int unsigned LenMax   = (MAX_LINE < BufBytes) ? BufBytes : MAX_LINE;
  localparam int unsigned LenW     = $clog2(LenMax + 1);
  localparam int unsigned RepLen   = Pre + 4;
  localparam bit          ToEn     = (LINE_TIMEOUT_CYCLES != 0);
  localparam logic [24:0] ToLim    = 25'(LINE_TIMEOUT_CYCLES);

  logic [2:0]      state_q;
  logic [7:0]      line_q [BufBytes];
  logic [LenW-1:0] len_q;
  logic            ovf_q;
  logic [24:0]     cnt_q;
  logic [7:0]      reply_q [RepLen];
  logic [2:0]      rlen_q, ridx_q;
  logic            gap_q;
  logic [7:0]      addr_q, wdata_q;
`ifdef UART_CMD_ECHO_EN
  logic [7:0]      echo_q;
`endif

  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic [4:0] h1, h2, h3, h4;
  logic       is_w, is_r, write_ok, read_ok, is_term, timeout_hit, tx_slot;
  logic [7:0] tx_byte;

  always_comb begin
    h1       = hex_dec(line_q[1]);
    h2       = hex_dec(line_q[2]);
    h3       = hex_dec(line_q[3]);
    h4       = hex_dec(line_q[4]);
    is_w     = (line_q[0] == 8'h57) || (line_q[0] == 8'h77);
    is_r     = (line_q[0] == 8'h52) || (line_q[0] == 8'h72);
    write_ok = !ovf_q && (len_q == LenW'(5)) && is_w && h1[4] && h2[4] && h3[4] && h4[4];
    read_ok  = !ovf_q && (len_q == LenW'(3)) && is_r && h1[4] && h2[4];
    is_term  = (rx_fifo_data_out == 8'h0D) || (rx_fifo_data_out == 8'h0A);
    timeout_hit = ToEn && (state_q == S_FETCH) && (len_q != '0) && (cnt_q >= ToLim);

    tx_byte = 8'h00;
    for (int i = 0; i < RepLen; i++) begin
      if (ridx_q == 3'(i)) tx_byte = reply_q[i];
    end
    tx_slot = (state_q == S_SEND);
`ifdef UART_CMD_ECHO_EN
    if (state_q == S_ECHO) tx_byte = echo_q;
    tx_slot = tx_slot || (state_q == S_ECHO);
`endif

    // gap_q covers the cycle in which ready still reflects the pre-enqueue fill level
    start_uart_tx   = !reset && tx_slot && !gap_q && uart_tx_fifo_ready;
    uart_tx_data    = start_uart_tx ? tx_byte : 8'h00;
    rx_fifo_read_en = !reset && (state_q == S_FETCH) && !rx_fifo_empty && !timeout_hit;
    reg_we          = !reset && (state_q == S_EXEC) && write_ok;
    reg_re          = !reset && (state_q == S_EXEC) && read_ok;
    reg_addr        = (reg_we || reg_re) ? {h1[3:0], h2[3:0]} : addr_q;
    reg_wdata       = reg_we ? {h3[3:0], h4[3:0]} : wdata_q;
    cmd_busy        = !reset &&
                      ((state_q == S_EXEC) || (state_q == S_READ) || (state_q == S_SEND));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      rlen_q  <= '0;
      ridx_q  <= '0;
      gap_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < BufBytes; i++) line_q[i] <= '0;
      for (int i = 0; i < RepLen; i++) reply_q[i] <= '0;
`ifdef UART_CMD_ECHO_EN
      echo_q  <= '0;
`endif
    end else begin
      gap_q <= start_uart_tx;
      case (state_q)
        S_FETCH: begin
          if (timeout_hit) begin
            len_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
          end else begin
            if (len_q != '0 && cnt_q != '1) cnt_q <= cnt_q + 25'd1;
            if (rx_fifo_read_en) state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (is_term) begin
            // Empty lines (e.g. the LF of a CRLF pair) are dropped silently.
            state_q <= (len_q == '0 && !ovf_q) ? S_FETCH : S_EXEC;
          end else if (len_q < LenW'(MAX_LINE)) begin
            for (int i = 0; i < BufBytes; i++) begin
              if (len_q == LenW'(i)) line_q[i] <= rx_fifo_data_out;
            end
            len_q   <= len_q + LenW'(1);
            cnt_q   <= '0;
`ifdef UART_CMD_ECHO_EN
            echo_q  <= rx_fifo_data_out;
            state_q <= S_ECHO;
`else
            state_q <= S_FETCH;
`endif
          end else begin
            ovf_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_EXEC: begin
          ridx_q <= '0;
`ifdef UART_CMD_ECHO_EN
          reply_q[0] <= 8'h0D;
          reply_q[1] <= 8'h0A;
`endif
          reply_q[Pre+1] <= 8'h0D;
          reply_q[Pre+2] <= 8'h0A;
          if (write_ok) begin
            addr_q         <= reg_addr;
            wdata_q        <= reg_wdata;
            reply_q[Pre]   <= 8'h4B;
            rlen_q         <= 3'(Pre + 3);
            state_q        <= S_SEND;
          end else if (read_ok) begin
            addr_q         <= reg_addr;
            rlen_q         <= 3'(Pre + 4);
            state_q        <= S_READ;
          end else begin
            reply_q[Pre]   <= 8'h45;
            rlen_q         <= 3'(Pre + 3);
            state_q        <= S_SEND;
          end
        end
        S_READ: begin
          reply_q[Pre]   <= hex_enc(reg_rdata[7:4]);
          reply_q[Pre+1] <= hex_enc(reg_rdata[3:0]);
          reply_q[Pre+2] <= 8'h0D;
          reply_q[Pre+3] <= 8'h0A;
          state_q        <= S_SEND;
        end
        S_SEND: begin
          if (start_uart_tx) begin
            if (ridx_q == rlen_q - 3'd1) begin
              len_q   <= '0;
              ovf_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_FETCH;
            end else begin
              ridx_q  <= ridx_q + 3'd1;
            end
          end
        end
`ifdef UART_CMD_ECHO_EN
        S_ECHO: begin
          if (start_uart_tx) state_q <= S_FETCH;
        end
`endif
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of command lines plus back-pressure,
// timeout and mid-reply reset sequences. Bench RX FIFO and TX log are modelled here.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_fifo_empty;
  logic [7:0] rx_fifo_data_out = 8'h00;
  logic       rx_fifo_read_en;
  logic       uart_tx_fifo_ready;
  logic       start_uart_tx;
  logic [7:0] uart_tx_data;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata;
  logic       cmd_busy;

  always #5 clk = ~clk;

  uart_cmd_parser #(.MAX_LINE(8), .LINE_TIMEOUT_CYCLES(50)) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_fifo_empty     (rx_fifo_empty),
    .rx_fifo_data_out  (rx_fifo_data_out),
    .rx_fifo_read_en   (rx_fifo_read_en),
    .uart_tx_fifo_ready(uart_tx_fifo_ready),
    .start_uart_tx     (start_uart_tx),
    .uart_tx_data      (uart_tx_data),
    .reg_addr          (reg_addr),
    .reg_wdata         (reg_wdata),
    .reg_we            (reg_we),
    .reg_re            (reg_re),
    .reg_rdata         (reg_rdata),
    .cmd_busy          (cmd_busy)
  );

  // RX FIFO model: data appears one cycle after the pop strobe.
  logic [7:0] rxmem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rx_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rx_fifo_read_en && !rx_fifo_empty) begin
      rx_fifo_data_out <= rxmem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: strobe counts, captured bus values, TX byte log and protocol violations.
  int we_cnt = 0, re_cnt = 0, viol_cnt = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;
  logic prev_start = 1'b0;
  logic [7:0] tx_q [$];

  always @(posedge clk) begin : mon
    int v;
    v = 0;
    prev_start <= start_uart_tx;
    if (start_uart_tx) begin
      tx_q.push_back(uart_tx_data);
      if (!uart_tx_fifo_ready || prev_start) v = v + 1;
    end
    if (reg_we && reg_re) v = v + 1;
    if (rx_fifo_read_en && rx_fifo_empty) v = v + 1;
    if (reg_we) begin
      we_cnt <= we_cnt + 1;
      we_addr <= reg_addr;
      we_data <= reg_wdata;
    end
    if (reg_re) begin
      re_cnt <= re_cnt + 1;
      re_addr <= reg_addr;
    end
    viol_cnt <= viol_cnt + v;
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_tx(input string name, input int from, input string exp);
    string a, e;
    a = "";
    e = "";
    for (int i = from; i < tx_q.size(); i++) a = $sformatf("%s%02x", a, tx_q[i]);
    for (int i = 0; i < exp.len(); i++) e = $sformatf("%s%02x", e, exp[i]);
    n_vec++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: tx bytes got [%s], expected [%s]", name, a, e);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rxmem[wr_ptr % 256] = s[i];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  typedef struct {
    string      cmd;
    logic [7:0] rdata;
    int         we;
    int         re;
    logic [7:0] addr;
    logic [7:0] wdata;
    string      tx;
  } vec_t;

  vec_t vecs [12];
  int base_we, base_re, base_tx;
  bit found;

  initial begin
    vecs[0]  = '{"W3A5C\r",      8'h00, 1, 0, 8'h3A, 8'h5C, "K\r\n"};
    vecs[1]  = '{"r3a\n",        8'hB7, 0, 1, 8'h3A, 8'h00, "B7\r\n"};
    vecs[2]  = '{"X12\r",        8'h00, 0, 0, 8'h00, 8'h00, "E\r\n"};
    vecs[3]  = '{"W3G00\r",      8'h00, 0, 0, 8'h00, 8'h00, "E\r\n"};
    vecs[4]  = '{"W123456789\r", 8'h00, 0, 0, 8'h00, 8'h00, "E\r\n"};
    vecs[5]  = '{"\r",           8'h00, 0, 0, 8'h00, 8'h00, ""};
    vecs[6]  = '{"wff00\n",      8'h00, 1, 0, 8'hFF, 8'h00, "K\r\n"};
    vecs[7]  = '{"Rc4\r",        8'h0F, 0, 1, 8'hC4, 8'h00, "0F\r\n"};
    vecs[8]  = '{"R1\r",         8'h00, 0, 0, 8'h00, 8'h00, "E\r\n"};
    vecs[9]  = '{"W12345\r",     8'h00, 0, 0, 8'h00, 8'h00, "E\r\n"};
    vecs[10] = '{"R0000000\r",   8'h00, 0, 0, 8'h00, 8'h00, "E\r\n"};
    vecs[11] = '{"Ra5\r",        8'h5A, 0, 1, 8'hA5, 8'h00, "5A\r\n"};

    reset = 1'b1;
    uart_tx_fifo_ready = 1'b1;
    reg_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {19'h0, rx_fifo_read_en, start_uart_tx, reg_we, reg_re, cmd_busy, uart_tx_data},
        32'h0);
    chk("reset_bus", {16'h0, reg_addr, reg_wdata}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      base_we = we_cnt;
      base_re = re_cnt;
      base_tx = tx_q.size();
      reg_rdata = vecs[i].rdata;
      push_str(vecs[i].cmd);
      repeat (60) @(negedge clk);
      chk($sformatf("v%0d_we_count", i), we_cnt - base_we, vecs[i].we);
      chk($sformatf("v%0d_re_count", i), re_cnt - base_re, vecs[i].re);
      if (vecs[i].we != 0) begin
        chk($sformatf("v%0d_we_addr", i), {24'h0, we_addr}, {24'h0, vecs[i].addr});
        chk($sformatf("v%0d_we_data", i), {24'h0, we_data}, {24'h0, vecs[i].wdata});
        chk($sformatf("v%0d_hold", i), {16'h0, reg_addr, reg_wdata},
            {16'h0, vecs[i].addr, vecs[i].wdata});
      end
      if (vecs[i].re != 0)
        chk($sformatf("v%0d_re_addr", i), {24'h0, re_addr}, {24'h0, vecs[i].addr});
      chk_tx($sformatf("v%0d_tx", i), base_tx, vecs[i].tx);
      chk($sformatf("v%0d_idle", i), {31'h0, cmd_busy}, 32'h0);
    end

    // TX back-pressure: nothing leaves while ready is low; CRLF yields one reply.
    uart_tx_fifo_ready = 1'b0;
    base_re = re_cnt;
    base_tx = tx_q.size();
    reg_rdata = 8'h9C;
    push_str("R01\r\n");
    repeat (100) @(negedge clk);
    chk("bp_no_tx", tx_q.size() - base_tx, 0);
    chk("bp_re_count", re_cnt - base_re, 1);
    chk("bp_busy", {31'h0, cmd_busy}, 32'h1);
    uart_tx_fifo_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk_tx("bp_tx", base_tx, "9C\r\n");
    chk("bp_re_addr", {24'h0, re_addr}, 32'h01);
    chk("bp_re_once", re_cnt - base_re, 1);

    // Line timeout: stale "W1" is discarded before "R02" arrives.
    base_we = we_cnt;
    base_re = re_cnt;
    base_tx = tx_q.size();
    reg_rdata = 8'h33;
    push_str("W1");
    repeat (80) @(negedge clk);
    push_str("R02\r");
    repeat (60) @(negedge clk);
    chk("to_we_count", we_cnt - base_we, 0);
    chk("to_re_count", re_cnt - base_re, 1);
    chk("to_re_addr", {24'h0, re_addr}, 32'h02);
    chk_tx("to_tx", base_tx, "33\r\n");

    // Reset during the reply: only the first byte may leave.
    base_we = we_cnt;
    base_tx = tx_q.size();
    push_str("W3A5C\r");
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (tx_q.size() > base_tx) found = 1'b1;
    end
    chk("rs_send_started", {31'h0, found}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_outputs",
        {19'h0, rx_fifo_read_en, start_uart_tx, reg_we, reg_re, cmd_busy, uart_tx_data},
        32'h0);
    chk("rs_bus", {16'h0, reg_addr, reg_wdata}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk_tx("rs_tx", base_tx, "K");
    chk("rs_we_count", we_cnt - base_we, 1);

    chk("protocol_violations", viol_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
